// File: rtl/axi_lite_regfile.sv
// AXI-Lite slave register bank with read-only status words and independent read/write FSMs.
// Optional build macro AXIL_REGFILE_W1C_EN: W1C_MASK registers become write-1-to-clear with hw_set OR-in.
module axi_lite_regfile #(
  parameter int unsigned         ADDR_WIDTH = 32,
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK   = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int unsigned SEL_WIDTH  = $clog2(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLV   = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return 64'(addr >> ADDR_LSB) < 64'(NUM_REGS);
  endfunction

  function automatic logic [SEL_WIDTH-1:0] reg_sel(input logic [ADDR_WIDTH-1:0] addr);
    return SEL_WIDTH'(addr >> ADDR_LSB);
  endfunction

  logic [DATA_WIDTH-1:0] regs      [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_nxt  [NUM_REGS];
  logic [DATA_WIDTH-1:0] status_arr[NUM_REGS];

  w_state_t              w_state, w_state_nxt;
  logic                  awready_nxt, wready_nxt, bvalid_nxt;
  logic [1:0]            bresp_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_q_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_q_nxt;
  logic [STRB_WIDTH-1:0] strb_q, strb_q_nxt;
  logic                  aw_hs, w_hs;
  logic                  cm_en, cm_ok;
  logic [ADDR_WIDTH-1:0] cm_addr;
  logic [DATA_WIDTH-1:0] cm_data, strb_mask;
  logic [STRB_WIDTH-1:0] cm_strb;
  logic [NUM_REGS-1:0]   wr_hit;

  r_state_t              r_state, r_state_nxt;
  logic                  arready_nxt, rvalid_nxt;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic [1:0]            rresp_nxt;
  logic [SEL_WIDTH-1:0]  rd_sel;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // Write channel: collect AW and W in either order, commit once both halves are present.
  always_comb begin
    w_state_nxt = w_state;
    awready_nxt = awready;
    wready_nxt  = wready;
    bvalid_nxt  = bvalid;
    bresp_nxt   = bresp;
    addr_q_nxt  = addr_q;
    data_q_nxt  = data_q;
    strb_q_nxt  = strb_q;
    cm_en       = 1'b0;
    cm_addr     = awaddr;
    cm_data     = wdata;
    cm_strb     = wstrb;
    case (w_state)
      W_IDLE: begin
        awready_nxt = 1'b1;
        wready_nxt  = 1'b1;
        if (aw_hs && w_hs) begin
          cm_en = 1'b1;
        end else if (aw_hs) begin
          addr_q_nxt  = awaddr;
          awready_nxt = 1'b0;
          w_state_nxt = W_HAVE_ADDR;
        end else if (w_hs) begin
          data_q_nxt  = wdata;
          strb_q_nxt  = wstrb;
          wready_nxt  = 1'b0;
          w_state_nxt = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        cm_addr = addr_q;
        cm_en   = w_hs;
      end
      W_HAVE_DATA: begin
        cm_data = data_q;
        cm_strb = strb_q;
        cm_en   = aw_hs;
      end
      W_RESP: begin
        if (bready) begin
          bvalid_nxt  = 1'b0;
          awready_nxt = 1'b1;
          wready_nxt  = 1'b1;
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
    cm_ok = in_range(cm_addr) && !RO_MASK[reg_sel(cm_addr)];
    if (cm_en) begin
      w_state_nxt = W_RESP;
      awready_nxt = 1'b0;
      wready_nxt  = 1'b0;
      bvalid_nxt  = 1'b1;
      bresp_nxt   = cm_ok ? RESP_OKAY : RESP_SLV;
    end
  end

  // Per-register next value: strobed write, plus W1C clear/set when enabled.
  always_comb begin
    for (int b = 0; b < int'(STRB_WIDTH); b++) strb_mask[b*8 +: 8] = {8{cm_strb[b]}};
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      wr_hit[i]   = cm_en && cm_ok && (reg_sel(cm_addr) == SEL_WIDTH'(i));
      regs_nxt[i] = regs[i];
      if (wr_hit[i]) regs_nxt[i] = (regs[i] & ~strb_mask) | (cm_data & strb_mask);
`ifdef AXIL_REGFILE_W1C_EN
      if (W1C_MASK[i])
        regs_nxt[i] = (regs[i] & ~(wr_hit[i] ? (cm_data & strb_mask) : '0))
                      | hw_set[i*DATA_WIDTH +: DATA_WIDTH];
`endif
    end
  end

`ifndef AXIL_REGFILE_W1C_EN
  logic unused_w1c;
  assign unused_w1c = ^{hw_set, W1C_MASK};
`endif

  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      status_arr[i]                       = status_in[i*DATA_WIDTH +: DATA_WIDTH];
      ctrl_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
  end

  // Read channel: sample on AR handshake, hold the response until rready.
  always_comb begin
    r_state_nxt = r_state;
    arready_nxt = arready;
    rvalid_nxt  = rvalid;
    rdata_nxt   = rdata;
    rresp_nxt   = rresp;
    rd_sel      = reg_sel(araddr);
    if (r_state == R_IDLE) begin
      arready_nxt = 1'b1;
      if (arvalid && arready) begin
        r_state_nxt = R_DATA;
        arready_nxt = 1'b0;
        rvalid_nxt  = 1'b1;
        if (!in_range(araddr)) begin
          rdata_nxt = '0;
          rresp_nxt = RESP_SLV;
        end else begin
          rdata_nxt = RO_MASK[rd_sel] ? status_arr[rd_sel] : regs[rd_sel];
          rresp_nxt = RESP_OKAY;
        end
      end
    end else if (rready) begin
      r_state_nxt = R_IDLE;
      rvalid_nxt  = 1'b0;
      arready_nxt = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= '0;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      wr_pulse <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      w_state  <= w_state_nxt;
      r_state  <= r_state_nxt;
      awready  <= awready_nxt;
      wready   <= wready_nxt;
      bvalid   <= bvalid_nxt;
      bresp    <= bresp_nxt;
      arready  <= arready_nxt;
      rvalid   <= rvalid_nxt;
      rdata    <= rdata_nxt;
      rresp    <= rresp_nxt;
      addr_q   <= addr_q_nxt;
      data_q   <= data_q_nxt;
      strb_q   <= strb_q_nxt;
      wr_pulse <= wr_hit;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= regs_nxt[i];
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: 16 x 32-bit regs, reg3 read-only, reg4 marked W1C.
module tb_axi_lite_regfile;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 16;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [AW-1:0]   awaddr, araddr;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]      bresp, rresp;
  logic [NR*DW-1:0] ctrl_out, status_in, hw_set, snap;
  logic [NR-1:0]   wr_pulse;

  int checks = 0;
  int errors = 0;

  axi_lite_regfile #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
    .RO_MASK(16'h0008), .W1C_MASK(16'h0010)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .ctrl_out(ctrl_out), .status_in(status_in), .hw_set(hw_set), .wr_pulse(wr_pulse)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] reg_of(input int i);
    return ctrl_out[i*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Present W at once and AW after aw_lag cycles; returns just after the committing edge.
  task automatic send_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, input int aw_lag);
    logic aw_done, w_done, aw_f, w_f;
    int n;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    awaddr = addr; awvalid = (aw_lag == 0);
    while (!(aw_done && w_done) && n < 30) begin
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      tick();
      n++;
      if (aw_f) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_f)  begin w_done  = 1'b1; wvalid  = 1'b0; end
      if (n == aw_lag && !aw_done) awvalid = 1'b1;
    end
    if (!(aw_done && w_done)) check("write_handshake_timeout", 0, 1);
  endtask

  task automatic wait_bresp(output logic [1:0] resp);
    int n;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    check("bvalid_seen", 64'(bvalid), 1);
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bvalid_cleared", 64'(bvalid), 0);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp);
    logic fired;
    int n;
    fired = 1'b0; n = 0;
    araddr = addr; arvalid = 1'b1;
    while (!fired && n < 20) begin
      fired = arready;
      tick();
      n++;
    end
    arvalid = 1'b0;
    if (!fired) check("read_handshake_timeout", 0, 1);
    check("rvalid_latency", 64'(rvalid), 1);
    data = rdata; resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rvalid_cleared", 64'(rvalid), 0);
  endtask

  logic [DW-1:0] rd;
  logic [1:0]    rsp;

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0; hw_set = '0;
    status_in = '0;
    status_in[3*DW +: DW] = 32'h12345678;
    status_in[5*DW +: DW] = 32'hBAD0BAD0;
    repeat (3) tick();

    // reset state
    check("rst_awready", 64'(awready), 0);
    check("rst_wready", 64'(wready), 0);
    check("rst_arready", 64'(arready), 0);
    check("rst_bvalid_rvalid", 64'({bvalid, rvalid}), 0);
    check("rst_wr_pulse", 64'(wr_pulse), 0);
    check("rst_rdata_resp", 64'({rdata, bresp, rresp}), 0);
    check("rst_ctrl_zero", 64'(ctrl_out == '0), 1);
    aresetn = 1'b1;
    tick();
    check("idle_readies", 64'({awready, wready, arready}), 64'h7);

    // AW+W same cycle to reg2
    send_write(32'h08, 32'hDEADBEEF, 4'hF, 0);
    check("t1_bvalid_next_cycle", 64'(bvalid), 1);
    check("t1_wr_pulse", 64'(wr_pulse), 64'h0004);
    check("t1_reg2", 64'(reg_of(2)), 64'hDEADBEEF);
    tick();
    check("t1_wr_pulse_one_cycle", 64'(wr_pulse), 0);
    wait_bresp(rsp);
    check("t1_bresp", 64'(rsp), 0);
    axi_read(32'h08, rd, rsp);
    check("t1_rdata", 64'(rd), 64'hDEADBEEF);
    check("t1_rresp", 64'(rsp), 0);

    // W first, AW three cycles later, single byte strobe
    send_write(32'h08, 32'h000000AA, 4'h1, 3);
    check("t2_wr_pulse", 64'(wr_pulse), 64'h0004);
    wait_bresp(rsp);
    check("t2_bresp", 64'(rsp), 0);
    check("t2_reg2", 64'(reg_of(2)), 64'hDEADBEAA);

    // out of range write and read
    snap = ctrl_out;
    send_write(32'h40, 32'hFFFFFFFF, 4'hF, 0);
    check("t3_no_pulse", 64'(wr_pulse), 0);
    wait_bresp(rsp);
    check("t3_bresp", 64'(rsp), 64'h2);
    check("t3_ctrl_unchanged", 64'(ctrl_out == snap), 1);
    axi_read(32'h40, rd, rsp);
    check("t3_rdata", 64'(rd), 0);
    check("t3_rresp", 64'(rsp), 64'h2);

    // read-only status register 3
    axi_read(32'h0C, rd, rsp);
    check("t4_ro_rdata", 64'(rd), 64'h12345678);
    check("t4_ro_rresp", 64'(rsp), 0);
    send_write(32'h0C, 32'hFFFFFFFF, 4'hF, 0);
    check("t4_ro_no_pulse", 64'(wr_pulse), 0);
    wait_bresp(rsp);
    check("t4_ro_bresp", 64'(rsp), 64'h2);
    check("t4_ctrl_unchanged", 64'(ctrl_out == snap), 1);

    // response backpressure with a concurrent read on the other channel
    send_write(32'h14, 32'h00000055, 4'hF, 0);
    awaddr = 32'h18; awvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t5_b_stable", 64'({bvalid, bresp}), 64'h4);
      check("t5_aw_blocked", 64'(awready), 0);
    end
    axi_read(32'h08, rd, rsp);
    check("t5_concurrent_rdata", 64'(rd), 64'hDEADBEAA);
    check("t5_b_still_held", 64'({bvalid, bresp}), 64'h4);
    awvalid = 1'b0;
    wait_bresp(rsp);
    check("t5_bresp", 64'(rsp), 0);
    check("t5_reg5", 64'(reg_of(5)), 64'h55);
    check("t5_reg6_untouched", 64'(reg_of(6)), 0);

    // unaligned address low bits ignored, sparse strobe
    send_write(32'h1B, 32'h11223344, 4'hA, 0);
    wait_bresp(rsp);
    check("t6_reg6_strobe", 64'(reg_of(6)), 64'h11003300);

    // last register
    send_write(32'h3C, 32'hCAFEF00D, 4'hF, 0);
    check("t7_pulse15", 64'(wr_pulse), 64'h8000);
    wait_bresp(rsp);
    axi_read(32'h3C, rd, rsp);
    check("t7_reg15_rdata", 64'(rd), 64'hCAFEF00D);

    // simultaneous read and write of reg7: read sees the old value
    check("t8_all_ready", 64'({awready, wready, arready}), 64'h7);
    awaddr = 32'h1C; wdata = 32'h77; wstrb = 4'hF; araddr = 32'h1C;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("t8_rvalid", 64'(rvalid), 1);
    check("t8_rdata_old", 64'(rdata), 0);
    check("t8_reg7_new", 64'(reg_of(7)), 64'h77);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    wait_bresp(rsp);

    // reg4: hw_set pulse then write 0x05
    hw_set[4*DW +: DW] = 32'h0F;
    tick();
    hw_set = '0;
`ifdef AXIL_REGFILE_W1C_EN
    check("t9_hw_set", 64'(reg_of(4)), 64'h0F);
    send_write(32'h10, 32'h05, 4'hF, 0);
    check("t9_w1c", 64'(reg_of(4)), 64'h0A);
`else
    check("t9_hw_set_ignored", 64'(reg_of(4)), 0);
    send_write(32'h10, 32'h05, 4'hF, 0);
    check("t9_plain_rw", 64'(reg_of(4)), 64'h05);
`endif
    wait_bresp(rsp);

    // reset asserted while waiting in W_RESP
    send_write(32'h10, 32'hF0, 4'hF, 0);
`ifdef AXIL_REGFILE_W1C_EN
    check("t10_pre_reset_reg4", 64'(reg_of(4)), 64'h0A);
`else
    check("t10_pre_reset_reg4", 64'(reg_of(4)), 64'hF0);
`endif
    check("t10_in_resp", 64'(bvalid), 1);
    #2;
    aresetn = 1'b0;
    #1;
    check("t10_bvalid_dropped", 64'(bvalid), 0);
    check("t10_reg4_cleared", 64'(reg_of(4)), 0);
    tick();
    aresetn = 1'b1;
    tick();
    check("t10_readies_back", 64'({awready, wready, arready}), 64'h7);
    check("t10_reg2_cleared", 64'(reg_of(2)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
